// File: rtl/macarray_tile_sched_if.sv
// Job and tile handshake bundle between host, macarray_tile_sched and the macarray.
// master: the scheduler's view; slave: the host/array environment's view.
interface macarray_tile_sched_if;
  logic        JOB_VALID;
  logic        JOB_READY;
  logic [1:0]  JOB_MT;
  logic [1:0]  JOB_NT;
  logic [1:0]  JOB_KT;
  logic [11:0] JOB_MNT;
  logic        ABORT;
  logic        TILE_START;
  logic [11:0] TILE_MNT;
  logic        TILE_ACC;
  logic [5:0]  TILE_BASE_I;
  logic [5:0]  TILE_BASE_W;
  logic [5:0]  TILE_BASE_O;
  logic [5:0]  TILE_IDX;
  logic        TILE_DONE;
  logic        BUSY;
  logic        JOB_DONE;
  logic        ERR;

  modport master (
    input  JOB_VALID, JOB_MT, JOB_NT, JOB_KT, JOB_MNT, ABORT, TILE_DONE,
    output JOB_READY, TILE_START, TILE_MNT, TILE_ACC, TILE_BASE_I, TILE_BASE_W,
           TILE_BASE_O, TILE_IDX, BUSY, JOB_DONE, ERR
  );

  modport slave (
    output JOB_VALID, JOB_MT, JOB_NT, JOB_KT, JOB_MNT, ABORT, TILE_DONE,
    input  JOB_READY, TILE_START, TILE_MNT, TILE_ACC, TILE_BASE_I, TILE_BASE_W,
           TILE_BASE_O, TILE_IDX, BUSY, JOB_DONE, ERR
  );
endinterface

// File: rtl/macarray_tile_sched.sv
// GEMM tile scheduler: walks the (m, n, k) tile loop and launches one tile at a time.
// Optional watchdog on the tile-done wait is enabled by defining TILE_SCHED_WDT_EN.
module macarray_tile_sched #(
  parameter int unsigned TILE_WORDS = 4,
  parameter int unsigned WDT_CYCLES = 255
) (
  input logic                   CLK,
  input logic                   RST,
  macarray_tile_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  mt, nt, kt;
  logic [1:0]  m, n, k, m_nxt, n_nxt, k_nxt;
  logic [5:0]  idx, idx_nxt;
  logic        accept, last;
  logic        job_ready, tile_start, job_done, busy, tile_acc;
  logic [5:0]  base_i, base_w, base_o;
  logic [11:0] mnt;
`ifdef TILE_SCHED_WDT_EN
  logic [15:0] wdt;
  logic        wdt_fire;
  logic        err;
`endif

  function automatic logic [5:0] tile_addr(input logic [1:0] outer,
                                           input logic [1:0] span_m1,
                                           input logic [1:0] inner);
    logic [7:0] lin;
    lin = 8'(outer) * (8'(span_m1) + 8'd1) + 8'(inner);
    return 6'(lin * 8'(TILE_WORDS));
  endfunction

  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    n_nxt     = n;
    k_nxt     = k;
    idx_nxt   = idx;
    accept    = 1'b0;
    last      = (m == mt) && (n == nt) && (k == kt);
`ifdef TILE_SCHED_WDT_EN
    wdt_fire  = 1'b0;
`endif
    if (state != IDLE && bus.ABORT) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.JOB_VALID && !bus.ABORT) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
          m_nxt     = '0;
          n_nxt     = '0;
          k_nxt     = '0;
          idx_nxt   = '0;
        end
        ISSUE: state_nxt = WAIT;
        WAIT: begin
          if (bus.TILE_DONE) begin
            if (last) begin
              state_nxt = FIN;
            end else begin
              state_nxt = ISSUE;
              idx_nxt   = idx + 6'd1;
              // k innermost, carrying into n, then into m
              if (k != kt) begin
                k_nxt = k + 2'd1;
              end else begin
                k_nxt = '0;
                if (n != nt) begin
                  n_nxt = n + 2'd1;
                end else begin
                  n_nxt = '0;
                  m_nxt = m + 2'd1;
                end
              end
            end
          end
`ifdef TILE_SCHED_WDT_EN
          else if (wdt == 16'(WDT_CYCLES - 1)) begin
            wdt_fire  = 1'b1;
            state_nxt = FIN;
          end
`endif
        end
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mt         <= '0;
      nt         <= '0;
      kt         <= '0;
      m          <= '0;
      n          <= '0;
      k          <= '0;
      idx        <= '0;
      mnt        <= '0;
      base_i     <= '0;
      base_w     <= '0;
      base_o     <= '0;
      tile_acc   <= 1'b0;
      tile_start <= 1'b0;
      job_done   <= 1'b0;
      busy       <= 1'b0;
      job_ready  <= 1'b1;
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      n     <= n_nxt;
      k     <= k_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        mt  <= bus.JOB_MT;
        nt  <= bus.JOB_NT;
        kt  <= bus.JOB_KT;
        mnt <= bus.JOB_MNT;
      end
      // On accept all counters are zero, so the stale kt/nt cannot affect the first bases.
      if (state_nxt == ISSUE) begin
        base_i   <= tile_addr(m_nxt, kt, k_nxt);
        base_w   <= tile_addr(k_nxt, nt, n_nxt);
        base_o   <= tile_addr(m_nxt, nt, n_nxt);
        tile_acc <= (k_nxt != 2'd0);
      end
      tile_start <= (state_nxt == ISSUE);
      job_done   <= (state_nxt == FIN);
      busy       <= (state_nxt != IDLE);
      job_ready  <= (state_nxt == IDLE);
    end
  end

`ifdef TILE_SCHED_WDT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdt <= '0;
      err <= 1'b0;
    end else begin
      if (state_nxt == WAIT) wdt <= (state == WAIT) ? wdt + 16'd1 : '0;
      if (accept)        err <= 1'b0;
      else if (wdt_fire) err <= 1'b1;
    end
  end
  assign bus.ERR = err;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.JOB_READY   = job_ready;
  assign bus.TILE_START  = tile_start;
  assign bus.TILE_MNT    = mnt;
  assign bus.TILE_ACC    = tile_acc;
  assign bus.TILE_BASE_I = base_i;
  assign bus.TILE_BASE_W = base_w;
  assign bus.TILE_BASE_O = base_o;
  assign bus.TILE_IDX    = idx;
  assign bus.BUSY        = busy;
  assign bus.JOB_DONE    = job_done;

endmodule

// File: tb/tb_macarray_tile_sched.sv
// Self-checking bench for macarray_tile_sched: randomized jobs against a nested-loop tile model.
// Watchdog scenario follows TILE_SCHED_WDT_EN.
module tb_macarray_tile_sched;
  localparam int unsigned TW  = 4;
  localparam int unsigned WDT = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  macarray_tile_sched_if bus();
  macarray_tile_sched #(.TILE_WORDS(TW), .WDT_CYCLES(WDT)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct packed {
    logic [5:0]  idx;
    logic [5:0]  bi;
    logic [5:0]  bw;
    logic [5:0]  bo;
    logic        acc;
    logic [11:0] mnt;
  } tile_t;

  int    total = 0;
  int    bad   = 0;
  tile_t obs[$];
  tile_t exp_q[$];
  int    start_cyc[$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic void build_model(input int mt, input int nt, input int kt, input logic [11:0] mnt);
    tile_t t;
    int    i = 0;
    exp_q.delete();
    for (int m = 0; m <= mt; m++)
      for (int n = 0; n <= nt; n++)
        for (int k = 0; k <= kt; k++) begin
          t.idx = 6'(i);
          t.bi  = 6'((m * (kt + 1) + k) * TW);
          t.bw  = 6'((k * (nt + 1) + n) * TW);
          t.bo  = 6'((m * (nt + 1) + n) * TW);
          t.acc = (k != 0);
          t.mnt = mnt;
          exp_q.push_back(t);
          i++;
        end
  endfunction

  // Drives one job; answers each start with TILE_DONE after a random delay; records starts.
  task automatic run_job(input logic [1:0] mt, input logic [1:0] nt, input logic [1:0] kt,
                         input logic [11:0] mnt, input int dmin, input int dmax, input bit poke,
                         output int done_cyc, output int last_done, output bit timeout,
                         output logic err_at_done, output logic ready_at_done);
    int    cnt = 0;
    tile_t t;
    obs.delete();
    start_cyc.delete();
    done_cyc = -1; last_done = -1; timeout = 1'b1; err_at_done = 1'bx; ready_at_done = 1'bx;
    bus.JOB_MT = mt; bus.JOB_NT = nt; bus.JOB_KT = kt; bus.JOB_MNT = mnt;
    bus.JOB_VALID = 1'b1;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      step();
      bus.JOB_VALID = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (poke) bus.JOB_MNT = 12'($urandom);
      bus.TILE_DONE = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.TILE_DONE = 1'b1;
          last_done = cyc;
        end
      end
      if (bus.TILE_START) begin
        t.idx = bus.TILE_IDX; t.bi = bus.TILE_BASE_I; t.bw = bus.TILE_BASE_W;
        t.bo = bus.TILE_BASE_O; t.acc = bus.TILE_ACC; t.mnt = bus.TILE_MNT;
        obs.push_back(t);
        start_cyc.push_back(cyc);
        cnt = int'($urandom_range(dmin, dmax));
      end
      if (bus.JOB_DONE) begin
        done_cyc = cyc; err_at_done = bus.ERR; ready_at_done = bus.JOB_READY;
        bus.JOB_VALID = 1'b0; bus.TILE_DONE = 1'b0; timeout = 1'b0;
        break;
      end
    end
    bus.JOB_VALID = 1'b0;
    bus.TILE_DONE = 1'b0;
  endtask

  task automatic test_reset();
    bus.JOB_VALID = 0; bus.ABORT = 0; bus.TILE_DONE = 0;
    bus.JOB_MT = 0; bus.JOB_NT = 0; bus.JOB_KT = 0; bus.JOB_MNT = 0;
    RST = 1'b1;
    step(); step();
    total++; if (bus.JOB_READY !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.JOB_READY); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    total++; if (bus.TILE_START !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", bus.TILE_START); end
    total++; if (bus.JOB_DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.JOB_DONE); end
    total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.ERR); end
    total++; if (bus.TILE_ACC !== 1'b0) begin bad++; $display("FAIL reset_acc: got %b want 0", bus.TILE_ACC); end
    total++; if ({bus.TILE_BASE_I, bus.TILE_BASE_W, bus.TILE_BASE_O} !== 18'd0) begin
      bad++; $display("FAIL reset_bases: got %0d/%0d/%0d want 0/0/0", bus.TILE_BASE_I, bus.TILE_BASE_W, bus.TILE_BASE_O); end
    total++; if (bus.TILE_IDX !== 6'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.TILE_IDX); end
    total++; if (bus.TILE_MNT !== 12'd0) begin bad++; $display("FAIL reset_mnt: got %h want 0", bus.TILE_MNT); end
    RST = 1'b0;
  endtask

  task automatic test_single_tile();
    int dc, ld; bit to; logic e, r;
    run_job(2'd0, 2'd0, 2'd0, 12'hA5C, 3, 3, 1'b0, dc, ld, to, e, r);
    build_model(0, 0, 0, 12'hA5C);
    total++; if (to) begin bad++; $display("FAIL single_timeout: got no JOB_DONE want JOB_DONE"); end
    total++; if (obs.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", obs.size()); end
    total++; if (obs.size() > 0 && obs[0] !== exp_q[0]) begin bad++; $display("FAIL single_tile: got %h want %h", obs[0], exp_q[0]); end
    total++; if (start_cyc.size() > 0 && start_cyc[0] != 1) begin bad++; $display("FAIL single_start_lat: got %0d want 1", start_cyc[0]); end
    total++; if (ld != 4) begin bad++; $display("FAIL single_done_in: got %0d want 4", ld); end
    total++; if (dc != ld + 1) begin bad++; $display("FAIL single_jobdone_lat: got %0d want %0d", dc, ld + 1); end
    total++; if (r !== 1'b0) begin bad++; $display("FAIL single_ready_at_done: got %b want 0", r); end
    step();
    total++; if (bus.JOB_READY !== 1'b1) begin bad++; $display("FAIL single_ready_after: got %b want 1", bus.JOB_READY); end
    total++; if (bus.JOB_DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL single_after: got done=%b busy=%b want 0/0", bus.JOB_DONE, bus.BUSY); end
  endtask

  task automatic test_tile_loop();
    int dc, ld; bit to; logic e, r;
    run_job(2'd1, 2'd1, 2'd1, 12'h3C1, 1, 1, 1'b0, dc, ld, to, e, r);
    build_model(1, 1, 1, 12'h3C1);
    total++; if (to || obs.size() != 8) begin bad++; $display("FAIL loop_count: got %0d timeout=%0b want 8", obs.size(), to); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL loop_tile%0d: got %h want %h", i, obs[i], exp_q[i]); end
      total++; if (start_cyc[i] != 1 + 2 * i) begin bad++; $display("FAIL loop_period%0d: got %0d want %0d", i, start_cyc[i], 1 + 2 * i); end
    end
    if (obs.size() == 8) begin
      total++; if ({obs[3].bi, obs[3].bw, obs[3].bo, obs[3].acc} !== {6'd4, 6'd12, 6'd4, 1'b1}) begin
        bad++; $display("FAIL loop_t3: got %0d/%0d/%0d acc=%b want 4/12/4 acc=1", obs[3].bi, obs[3].bw, obs[3].bo, obs[3].acc); end
      total++; if ({obs[7].bi, obs[7].bw, obs[7].bo} !== {6'd12, 6'd12, 6'd12}) begin
        bad++; $display("FAIL loop_t7: got %0d/%0d/%0d want 12/12/12", obs[7].bi, obs[7].bw, obs[7].bo); end
    end
    total++; if (dc != ld + 1) begin bad++; $display("FAIL loop_jobdone_lat: got %0d want %0d", dc, ld + 1); end
    step();
  endtask

  task automatic test_random_jobs();
    int dc, ld; bit to; logic e, r;
    logic [1:0] mt, nt, kt; logic [11:0] mnt;
    for (int j = 0; j < 6; j++) begin
      mt = 2'($urandom_range(0, 3)); nt = 2'($urandom_range(0, 3)); kt = 2'($urandom_range(0, 3));
      mnt = 12'($urandom);
      run_job(mt, nt, kt, mnt, 1, 4, 1'b0, dc, ld, to, e, r);
      build_model(int'(mt), int'(nt), int'(kt), mnt);
      total++; if (to || obs.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count: got %0d timeout=%0b want %0d", j, obs.size(), to, exp_q.size()); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_tile%0d: got %h want %h", j, i, obs[i], exp_q[i]); end
      end
      total++; if (dc != ld + 1) begin bad++; $display("FAIL rand%0d_jobdone_lat: got %0d want %0d", j, dc, ld + 1); end
      step();
      total++; if (bus.JOB_READY !== 1'b1) begin bad++; $display("FAIL rand%0d_ready: got %b want 1", j, bus.JOB_READY); end
    end
  endtask

  task automatic test_full_size();
    int dc, ld; bit to; logic e, r;
    run_job(2'd3, 2'd3, 2'd3, 12'h7E7, 1, 2, 1'b1, dc, ld, to, e, r);
    build_model(3, 3, 3, 12'h7E7);
    total++; if (to || obs.size() != 64) begin bad++; $display("FAIL full_count: got %0d timeout=%0b want 64", obs.size(), to); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL full_tile%0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
    if (obs.size() == 64) begin
      total++; if ({obs[63].bi, obs[63].bw, obs[63].bo, obs[63].idx} !== {6'd60, 6'd60, 6'd60, 6'd63}) begin
        bad++; $display("FAIL full_last: got %0d/%0d/%0d idx=%0d want 60/60/60 idx=63", obs[63].bi, obs[63].bw, obs[63].bo, obs[63].idx); end
    end
    step();
    total++; if (bus.JOB_DONE !== 1'b0 || bus.JOB_READY !== 1'b1 || bus.TILE_START !== 1'b0) begin
      bad++; $display("FAIL full_after: got done=%b ready=%b start=%b want 0/1/0", bus.JOB_DONE, bus.JOB_READY, bus.TILE_START); end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    bit saw_done = 1'b0;
    bus.ABORT = 1'b1; bus.JOB_VALID = 1'b1;
    bus.JOB_MT = 2'd1; bus.JOB_NT = 2'd1; bus.JOB_KT = 2'd1; bus.JOB_MNT = 12'h111;
    step();
    bus.ABORT = 1'b0; bus.JOB_VALID = 1'b0;
    total++; if (bus.BUSY !== 1'b0 || bus.TILE_START !== 1'b0 || bus.JOB_READY !== 1'b1) begin
      bad++; $display("FAIL abort_idle: got busy=%b start=%b ready=%b want 0/0/1", bus.BUSY, bus.TILE_START, bus.JOB_READY); end
    bus.JOB_VALID = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      bus.JOB_VALID = 1'b0; bus.TILE_DONE = 1'b0;
      if (bus.JOB_DONE) saw_done = 1'b1;
      if (bus.TILE_START) begin
        if (bus.TILE_IDX == 6'd2) found = 1'b1;
        else begin step(); bus.TILE_DONE = 1'b1; end
      end
    end
    bus.TILE_DONE = 1'b0;
    total++; if (!found) begin bad++; $display("FAIL abort_reach_t2: got no tile 2 want tile 2 start"); end
    step();
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    total++; if (bus.JOB_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL abort_to_idle: got ready=%b busy=%b want 1/0", bus.JOB_READY, bus.BUSY); end
    total++; if (bus.JOB_DONE !== 1'b0 || bus.TILE_START !== 1'b0 || saw_done) begin
      bad++; $display("FAIL abort_no_pulse: got done=%b start=%b earlier_done=%b want 0/0/0", bus.JOB_DONE, bus.TILE_START, saw_done); end
    bus.JOB_MT = 2'd0; bus.JOB_NT = 2'd0; bus.JOB_KT = 2'd0; bus.JOB_MNT = 12'h9B4; bus.JOB_VALID = 1'b1;
    step();
    bus.JOB_VALID = 1'b0;
    total++; if (bus.TILE_START !== 1'b1 || {bus.TILE_BASE_I, bus.TILE_BASE_W, bus.TILE_BASE_O} !== 18'd0) begin
      bad++; $display("FAIL abort_new_job: got start=%b bases=%0d/%0d/%0d want 1 0/0/0", bus.TILE_START, bus.TILE_BASE_I, bus.TILE_BASE_W, bus.TILE_BASE_O); end
    total++; if (bus.TILE_IDX !== 6'd0 || bus.TILE_ACC !== 1'b0 || bus.TILE_MNT !== 12'h9B4) begin
      bad++; $display("FAIL abort_new_fields: got idx=%0d acc=%b mnt=%h want 0 0 9b4", bus.TILE_IDX, bus.TILE_ACC, bus.TILE_MNT); end
    step();
    bus.TILE_DONE = 1'b1;
    step();
    bus.TILE_DONE = 1'b0;
    total++; if (bus.JOB_DONE !== 1'b1) begin bad++; $display("FAIL abort_new_done: got %b want 1", bus.JOB_DONE); end
    step();
  endtask

  task automatic test_reset_mid_job();
    bit bad_seen = 1'b0;
    bus.JOB_MT = 2'd3; bus.JOB_NT = 2'd3; bus.JOB_KT = 2'd3; bus.JOB_MNT = 12'hFFF; bus.JOB_VALID = 1'b1;
    step();
    bus.JOB_VALID = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++; if (bus.JOB_READY !== 1'b1 || bus.BUSY !== 1'b0 || bus.TILE_MNT !== 12'd0) begin
      bad++; $display("FAIL rst_mid: got ready=%b busy=%b mnt=%h want 1/0/000", bus.JOB_READY, bus.BUSY, bus.TILE_MNT); end
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.TILE_START !== 1'b0 || bus.JOB_DONE !== 1'b0) bad_seen = 1'b1;
    end
    total++; if (bad_seen) begin bad++; $display("FAIL rst_mid_quiet: got activity after reset want none"); end
  endtask

  task automatic test_watchdog();
    int dc, ld; bit to; logic e, r;
    int got = -1;
    bit saw_done = 1'b0;
    // TILE_DONE on the very cycle the watchdog would expire wins
    run_job(2'd0, 2'd0, 2'd0, 12'h042, int'(WDT), int'(WDT), 1'b0, dc, ld, to, e, r);
    total++; if (to || e !== 1'b0 || ld != 1 + int'(WDT)) begin
      bad++; $display("FAIL wdt_edge_done: got timeout=%0b err=%b done_in=%0d want 0 0 %0d", to, e, ld, 1 + int'(WDT)); end
    step();
    bus.JOB_MT = 2'd0; bus.JOB_NT = 2'd0; bus.JOB_KT = 2'd0; bus.JOB_VALID = 1'b1;
    step();
    bus.JOB_VALID = 1'b0;
`ifdef TILE_SCHED_WDT_EN
    for (int c = 1; c <= 60; c++) begin
      step();
      if (bus.JOB_DONE) begin got = c; e = bus.ERR; break; end
    end
    total++; if (got != 1 + int'(WDT)) begin bad++; $display("FAIL wdt_fire_time: got %0d want %0d", got, 1 + int'(WDT)); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL wdt_err: got %b want 1", e); end
    step();
    total++; if (bus.ERR !== 1'b1 || bus.JOB_READY !== 1'b1) begin
      bad++; $display("FAIL wdt_sticky: got err=%b ready=%b want 1/1", bus.ERR, bus.JOB_READY); end
    bus.JOB_VALID = 1'b1;
    step();
    bus.JOB_VALID = 1'b0;
    total++; if (bus.ERR !== 1'b0 || bus.TILE_START !== 1'b1) begin
      bad++; $display("FAIL wdt_err_clear: got err=%b start=%b want 0/1", bus.ERR, bus.TILE_START); end
`else
    for (int c = 1; c <= 300; c++) begin
      step();
      if (bus.JOB_DONE || bus.ERR) saw_done = 1'b1;
    end
    total++; if (saw_done || bus.BUSY !== 1'b1 || bus.ERR !== 1'b0) begin
      bad++; $display("FAIL wdt_off_wait: got done_or_err=%0b busy=%b err=%b want 0/1/0", saw_done, bus.BUSY, bus.ERR); end
`endif
    step();
    bus.TILE_DONE = 1'b1;
    for (int c = 0; c < 40 && got != -2; c++) begin
      step();
      bus.TILE_DONE = 1'b0;
      if (bus.JOB_DONE) got = -2;
    end
    total++; if (got != -2) begin bad++; $display("FAIL wdt_final_done: got no JOB_DONE want JOB_DONE"); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_tile_loop();
    test_random_jobs();
    test_full_size();
    test_abort();
    test_reset_mid_job();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/macarray_tile_sched.md
# macarray_tile_sched

Tile scheduler that sits between the host job interface and the `macarray` top level. It accepts one GEMM job described in 4x4 tile units and walks the (m, n, k) tile loop. For each tile it issues a one-cycle start with per-tile I/W/O base addresses and an accumulate flag, then waits for the array's tile-done before issuing the next tile. When the last tile completes it reports job completion to the host.

## Interface

Parameters:
- `TILE_WORDS`, default 4: memory words per tile; the base-address stride.
- `WDT_CYCLES`, default 255: watchdog limit in cycles. Used only when `TILE_SCHED_WDT_EN` is defined.

Ports:
- `CLK` input, 1: single clock; everything is rising-edge.
- `RST` input, 1: reset. **Synchronous, active-high.**
- `JOB_VALID` input, 1: job request.
- `JOB_READY` output, 1: scheduler idle and able to accept a job.
- `JOB_MT` input, 2: M tile count minus 1 (1..4 tiles).
- `JOB_NT` input, 2: N tile count minus 1.
- `JOB_KT` input, 2: K tile count minus 1.
- `JOB_MNT` input, 12: per-tile MNT configuration word, forwarded unchanged.
- `ABORT` input, 1: cancel the current job.
- `TILE_START` output, 1: one-cycle pulse that launches a tile on the array.
- `TILE_MNT` output, 12: latched copy of `JOB_MNT`.
- `TILE_ACC` output, 1: 1 when k != 0, so the tile accumulates into OMEM.
- `TILE_BASE_I` output, 6: I-memory base address.
- `TILE_BASE_W` output, 6: W-memory base address.
- `TILE_BASE_O` output, 6: O-memory base address.
- `TILE_IDX` output, 6: linear index of the tile being issued, 0..63.
- `TILE_DONE` input, 1: array reports that the current tile is finished.
- `BUSY` output, 1: job in progress.
- `JOB_DONE` output, 1: one-cycle pulse at job end.
- `ERR` output, 1: watchdog fired; sticky until the next job is accepted.

## Operation

State machine states: IDLE, ISSUE, WAIT, FIN.

- **IDLE**
  - `JOB_READY=1`.
  - On `JOB_VALID && JOB_READY`:
    - latch MT/NT/KT/MNT;
    - clear the m/n/k counters, `TILE_IDX` and `ERR`;
    - go to ISSUE.
- **ISSUE**
  - `TILE_START=1` for exactly this cycle.
  - Tile outputs are valid and stay stable until the next ISSUE.
  - Go to WAIT unconditionally. `TILE_DONE` is ignored in ISSUE.
- **WAIT**
  - Hold outputs.
  - On `TILE_DONE`, if the tile is the last one (m==MT, n==NT, k==KT): go to FIN.
  - On `TILE_DONE` otherwise: advance the counters and go to ISSUE.
    - k is innermost, then n, then m.
    - k wraps to 0 at KT and carries into n; n wraps to 0 at NT and carries into m.
    - `TILE_IDX` increments.
- **FIN**
  - `JOB_DONE=1` for one cycle.
  - Return to IDLE.

Address arithmetic (unsigned, 6-bit, never overflows because the maximum value is 60):
- `TILE_BASE_I = (m*(KT+1)+k)*TILE_WORDS`
- `TILE_BASE_W = (k*(NT+1)+n)*TILE_WORDS`
- `TILE_BASE_O = (m*(NT+1)+n)*TILE_WORDS`
- `TILE_ACC = (k != 0)`

Other rules:
- `BUSY=1` in ISSUE, WAIT and FIN.
- `JOB_VALID` while busy is not accepted; no queueing.
- `ABORT` has priority over every transition. In any non-IDLE state it goes to IDLE next cycle with no `JOB_DONE` and no `TILE_START`. `ABORT` in IDLE has no effect, and a simultaneous `JOB_VALID` is not accepted.
- Total tiles issued per job = (MT+1)(NT+1)(KT+1), from 1 up to 64.

## Timing

- Reset values: state IDLE; `JOB_READY=1`; `TILE_START=0`, `JOB_DONE=0`, `BUSY=0`, `ERR=0`, `TILE_ACC=0`; all bases, `TILE_IDX` and `TILE_MNT` = 0. `RST` mid-job discards the job silently.
- Job handshake at cycle c gives `TILE_START` at c+1.
- `TILE_DONE` sampled in WAIT at cycle d gives the next `TILE_START` at d+1, with the new addresses valid in the same cycle.
- The last `TILE_DONE` at d gives `JOB_DONE` at d+1 and `JOB_READY` at d+2.
- Minimum tile period is 2 cycles (ISSUE plus one WAIT cycle).
- All outputs are registered.

## Configuration

Macro: `TILE_SCHED_WDT_EN`.
- **Defined:** a counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - If it reaches `WDT_CYCLES` without `TILE_DONE`: set `ERR`, go to FIN, and pulse `JOB_DONE` with `ERR=1`.
  - `TILE_DONE` in that same cycle wins: normal completion, no error.
- **Not defined:** no counter; `ERR` is tied to 0; WAIT waits indefinitely.

## Test plan

- **Reset:** hold `RST` high for 2 cycles → `JOB_READY=1`, every other output 0.
- **Single tile:** MT=NT=KT=0, `TILE_DONE` returned 3 cycles after start → exactly one `TILE_START` with bases 0/0/0 and `ACC=0`, then `JOB_DONE` 1 cycle after `TILE_DONE`.
- **Tile loop:** MT=1, NT=1, KT=1, `TILE_DONE` 1 cycle after each start → 8 starts.
  - Tile 3 (m=0, n=1, k=1): I=4, W=12, O=4, `ACC=1`.
  - Tile 7: I=12, W=12, O=12.
  - `TILE_IDX` runs 0..7.
- **Full size:** MT=NT=KT=3 → 64 starts, last tile bases I=60, W=60, O=60, `JOB_DONE` once; `JOB_VALID` asserted while busy is never accepted.
- **Abort:** `ABORT` during WAIT of tile 2 → IDLE next cycle, no `JOB_DONE`; a new job is accepted 1 cycle later and its first tile has all bases 0.
- **Watchdog** (macro defined, `WDT_CYCLES=16`): withhold `TILE_DONE` → `ERR=1` and a `JOB_DONE` pulse 16 cycles after entering WAIT. With the macro undefined, the scheduler stays in WAIT with `ERR=0`.
